// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter: shares the test SoC RAM between the Z80 (via BUSRQ/BUSAK) and a host/debug port.
// Optional `Z80_ARB_HOLD_EN keeps the bus for HOLD_CYCLES idle cycles after the last host transaction.
module z80_bus_arbiter #(
  parameter int unsigned TIMEOUT     = 4096,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned WR_CYCLES   = 2,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        eclk,
  input  logic        ereset,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic        host_ack,
  output logic        host_err,
  output logic        host_owns,
  output logic        _busrq,
  input  logic        _busak,
  input  logic [15:0] z80_ab,
  input  logic [7:0]  z80_db_o,
  input  logic        z80_wr_n,
  input  logic        z80_mreq_n,
  output logic [15:0] ram_ab,
  output logic [7:0]  ram_di,
  output logic        ram_we_n,
  input  logic [7:0]  ram_do
);

  // One counter serves the BUSAK timeout, the access phase and the hold window.
  localparam int unsigned CMAX = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
  localparam int unsigned CW   = (CMAX > 256) ? $clog2(CMAX) : 8;

  typedef enum logic [2:0] {IDLE, REQ, ACCESS, ACK, GRANT, RELEASE} state_t;

  state_t        r_state;
  logic          r_busak_m;
  logic          r_busak_s;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [15:0]   r_addr;
  logic [7:0]    r_wdata;
  logic          r_busrq;
  logic          r_ack;
  logic          r_err;
  logic [7:0]    r_rdata;
  logic          w_owns;
  logic          w_access_done;

  assign w_owns        = (r_state == ACCESS) || (r_state == ACK) || (r_state == GRANT);
  assign w_access_done = (r_cnt == (r_we ? CW'(WR_CYCLES - 1) : CW'(RD_LAT - 1)));

  always_ff @(posedge eclk) begin
    if (ereset) begin
      r_state   <= IDLE;
      r_busak_m <= 1'b1;
      r_busak_s <= 1'b1;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_busrq   <= 1'b1;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_busak_m <= _busak;
      r_busak_s <= r_busak_m;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (host_req) begin
            r_we    <= host_we;
            r_addr  <= host_addr;
            r_wdata <= host_wdata;
            r_busrq <= 1'b0;
            r_cnt   <= '0;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (!r_busak_s) begin
            r_cnt   <= '0;
            r_state <= ACCESS;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_busrq <= 1'b1;
            r_cnt   <= '0;
            r_state <= RELEASE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ACCESS: begin
          if (w_access_done) begin
            if (!r_we) r_rdata <= ram_do;
            r_ack   <= 1'b1;
            r_cnt   <= '0;
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ACK: r_state <= GRANT;
        GRANT: begin
          if (host_req) begin
            r_we    <= host_we;
            r_addr  <= host_addr;
            r_wdata <= host_wdata;
            r_cnt   <= '0;
            r_state <= ACCESS;
          end
`ifdef Z80_ARB_HOLD_EN
          else if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
            r_busrq <= 1'b1;
            r_cnt   <= '0;
            r_state <= RELEASE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`else
          else begin
            r_busrq <= 1'b1;
            r_state <= RELEASE;
          end
`endif
        end
        RELEASE: if (r_busak_s) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Z80 path is purely combinational so the core never sees extra wait states.
  always_comb begin
    if (w_owns) begin
      ram_ab   = r_addr;
      ram_di   = r_wdata;
      ram_we_n = !((r_state == ACCESS) && r_we);
    end else begin
      ram_ab   = z80_ab;
      ram_di   = z80_db_o;
      ram_we_n = z80_wr_n | z80_mreq_n;
    end
  end

  assign host_rdata = r_rdata;
  assign host_ack   = r_ack;
  assign host_err   = r_err;
  assign host_owns  = w_owns;
  assign _busrq     = r_busrq;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed bench for z80_bus_arbiter: scoreboard of host transactions checked on host_ack.
module tb_z80_bus_arbiter;

  localparam int unsigned WR_CYC = 2;

  logic        eclk = 1'b0;
  logic        ereset;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic [7:0]  host_rdata;
  logic        host_ack;
  logic        host_err;
  logic        host_owns;
  logic        _busrq;
  logic        _busak;
  logic [15:0] z80_ab;
  logic [7:0]  z80_db_o;
  logic        z80_wr_n;
  logic        z80_mreq_n;
  logic [15:0] ram_ab;
  logic [7:0]  ram_di;
  logic        ram_we_n;
  logic [7:0]  ram_do;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [0:65535];
  logic [7:0] sdata [4];
  int         n_checks = 0;
  int         n_err    = 0;
  int         bcnt     = 0;
  bit         busak_tie = 1'b0;

  always #5 eclk = ~eclk;

  z80_bus_arbiter #(
    .TIMEOUT(16),
    .RD_LAT(2),
    .WR_CYCLES(WR_CYC),
    .HOLD_CYCLES(8)
  ) dut (
    .eclk(eclk), .ereset(ereset),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack), .host_err(host_err), .host_owns(host_owns),
    ._busrq(_busrq), ._busak(_busak),
    .z80_ab(z80_ab), .z80_db_o(z80_db_o), .z80_wr_n(z80_wr_n), .z80_mreq_n(z80_mreq_n),
    .ram_ab(ram_ab), .ram_di(ram_di), .ram_we_n(ram_we_n), .ram_do(ram_do)
  );

  // RAM model: asynchronous read, write on the clock edge while ram_we_n is low.
  assign ram_do = mem[ram_ab];
  always @(posedge eclk) begin
    if (ereset) begin
      mem[16'h0000] <= 8'hF5;
      mem[16'h0001] <= 8'h3E;
      mem[16'h0002] <= 8'h3C;
      mem[16'h0003] <= 8'h76;
      mem[16'h1234] <= 8'h11;
    end else if (!ram_we_n) begin
      mem[ram_ab] <= ram_di;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the Z80 grants the bus a few cycles after _busrq falls.
  task automatic tick;
    @(posedge eclk);
    #1;
    if (busak_tie || _busrq) begin
      bcnt   = 0;
      _busak = 1'b1;
    end else begin
      bcnt++;
      if (bcnt > 5) _busak = 1'b0;
    end
  endtask

  task automatic session(input int n, input logic we, input logic [15:0] a0);
    exp_t e;
    int   k, acks, falls, leaks, wcnt, errs;
    logic prev_rq;
    bit   done;
    k = 0; acks = 0; falls = 0; leaks = 0; wcnt = 0; errs = 0; done = 1'b0;
    prev_rq    = _busrq;
    host_we    = we;
    host_addr  = a0;
    host_wdata = sdata[0];
    host_req   = 1'b1;
    exp_q.push_back(exp_t'{we, a0, sdata[0]});
    for (int t = 0; t < 300 && !done; t++) begin
      tick;
      if (prev_rq && !_busrq) falls++;
      prev_rq = _busrq;
      if (!host_owns && (ram_ab !== z80_ab || ram_we_n !== (z80_wr_n | z80_mreq_n))) leaks++;
      if (host_owns && !ram_we_n && exp_q.size() > 0 &&
          ram_ab === exp_q[0].addr && ram_di === exp_q[0].data) wcnt++;
      if (host_err) errs++;
      if (host_ack) begin
        acks++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (e.we) begin
            check("wr_cycles", wcnt, WR_CYC);
            check("ram_wdata", {24'h0, mem[e.addr]}, {24'h0, e.data});
          end else begin
            check("rdata", {24'h0, host_rdata}, {24'h0, e.data});
          end
        end
        wcnt = 0;
        k++;
        if (k < n) begin
          host_addr  = a0 + 16'(k);
          host_wdata = sdata[k];
          exp_q.push_back(exp_t'{we, host_addr, sdata[k]});
        end else begin
          host_req = 1'b0;
        end
      end
      if (k == n && _busrq && !host_owns) done = 1'b1;
    end
    check("session_done", {31'h0, done}, 32'd1);
    check("ack_count", acks, n);
    check("busrq_falls", falls, 1);
    check("z80_mux_leaks", leaks, 0);
    check("err_pulses", errs, 0);
  endtask

  initial begin
    int   errcyc, acks;
    bit   seen;
    ereset = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    _busak = 1'b1; z80_ab = '0; z80_db_o = '0; z80_wr_n = 1'b1; z80_mreq_n = 1'b1;
    tick; tick;
    check("rst_busrq", {31'h0, _busrq}, 32'd1);
    check("rst_ack", {31'h0, host_ack}, 32'd0);
    check("rst_err", {31'h0, host_err}, 32'd0);
    check("rst_rdata", {24'h0, host_rdata}, 32'd0);
    check("rst_owns", {31'h0, host_owns}, 32'd0);
    ereset = 1'b0;
    tick;

    // Mux transparency: Z80 write of 0x55 to 0x2000.
    z80_ab = 16'h2000; z80_db_o = 8'h55; z80_mreq_n = 1'b0; z80_wr_n = 1'b1;
    #1;
    check("mux_we_idle", {31'h0, ram_we_n}, 32'd1);
    check("mux_ab", {16'h0, ram_ab}, 32'h2000);
    z80_wr_n = 1'b0;
    #1;
    check("mux_we_low", {31'h0, ram_we_n}, 32'd0);
    check("mux_di", {24'h0, ram_di}, 32'h55);
    tick;
    z80_wr_n = 1'b1; z80_mreq_n = 1'b1;
    #1;
    check("mux_we_end", {31'h0, ram_we_n}, 32'd1);
    check("mux_mem", {24'h0, mem[16'h2000]}, 32'h55);

    // Single host write while the Z80 keeps fetching from 0x0040.
    z80_ab = 16'h0040; z80_mreq_n = 1'b0; z80_wr_n = 1'b1;
    sdata[0] = 8'h3E;
    session(1, 1'b1, 16'h0100);
    repeat (4) tick;
    check("resume_ab", {16'h0, ram_ab}, 32'h0040);
    check("resume_owns", {31'h0, host_owns}, 32'd0);

    // Burst of four reads under one bus grant.
    sdata[0] = 8'hF5; sdata[1] = 8'h3E; sdata[2] = 8'h3C; sdata[3] = 8'h76;
    session(4, 1'b0, 16'h0000);
    repeat (4) tick;

    // BUSAK never arrives: abort after TIMEOUT cycles.
    busak_tie = 1'b1;
    host_we = 1'b0; host_addr = 16'h0200; host_req = 1'b1;
    tick;
    check("to_busrq_low", {31'h0, _busrq}, 32'd0);
    errcyc = 0; acks = 0;
    for (int i = 1; i <= 40 && errcyc == 0; i++) begin
      tick;
      if (host_ack) acks++;
      if (host_err) begin
        errcyc   = i;
        host_req = 1'b0;
        check("to_busrq_rel", {31'h0, _busrq}, 32'd1);
      end
    end
    check("to_err_cycle", errcyc, 16);
    tick;
    check("to_err_pulse", {31'h0, host_err}, 32'd0);
    repeat (4) begin
      tick;
      if (host_ack) acks++;
    end
    check("to_no_ack", acks, 0);
    busak_tie = 1'b0;

    // Reset in the middle of a write to 0x1234.
    host_we = 1'b1; host_addr = 16'h1234; host_wdata = 8'hAA; host_req = 1'b1;
    z80_mreq_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick;
      if (!ram_we_n && host_owns) seen = 1'b1;
    end
    check("mw_reached", {31'h0, seen}, 32'd1);
    ereset = 1'b1; host_req = 1'b0;
    tick;
    check("mw_we_n", {31'h0, ram_we_n}, 32'd1);
    check("mw_busrq", {31'h0, _busrq}, 32'd1);
    check("mw_owns", {31'h0, host_owns}, 32'd0);
    check("mw_rdata", {24'h0, host_rdata}, 32'd0);
    ereset = 1'b0;
    tick; tick;
    check("mw_idle", {31'h0, _busrq}, 32'd1);

`ifdef Z80_ARB_HOLD_EN
    // Second request inside the hold window reuses the grant; release after 8 idle cycles.
    begin
      int rises, rel;
      logic prev;
      rises = 0; rel = 0;
      repeat (4) tick;
      host_we = 1'b1; host_addr = 16'h0300; host_wdata = 8'h12; host_req = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        tick;
        if (host_ack) seen = 1'b1;
      end
      host_req = 1'b0;
      prev = _busrq;
      repeat (5) begin
        tick;
        if (!prev && _busrq) rises++;
        prev = _busrq;
      end
      host_addr = 16'h0301; host_wdata = 8'h34; host_req = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        tick;
        if (!prev && _busrq) rises++;
        prev = _busrq;
        if (host_ack) seen = 1'b1;
      end
      check("hold_second_ack", {31'h0, seen}, 32'd1);
      check("hold_no_rise", rises, 0);
      host_req = 1'b0;
      for (int i = 1; i <= 20 && rel == 0; i++) begin
        tick;
        if (_busrq) rel = i;
      end
      check("hold_release", rel, 9);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
